// File: rtl/pluto_epp_regbank.sv
// pluto_epp_regbank: parametrised EPP slave register bank with integrated watchdog.
// Optional macro PLUTO_EPP_READBACK_EN: read groups 10..10+NCH-1 return the channel command words.
module pluto_epp_regbank #(
    parameter int NCH      = 4,
    parameter int VW       = 12,
    parameter int SDLY     = 4,
    parameter int WDT_W    = 8,
    parameter int WDT_LOAD = 255
) (
    input  logic              clk,
    input  logic              nReset,
    inout  wire  [7:0]        pport_data,
    input  logic              nWrite,
    input  logic              nDataStr,
    input  logic              nAddrStr,
    output logic              nWait,
    input  logic              wdt_tick,
    input  logic [NCH*32-1:0] pos,
    input  logic [15:0]       din,
    output logic [NCH*VW-1:0] vel,
    output logic [13:0]       dout,
    output logic [15:0]       cfg,
    output logic              outputs_off
);
    logic [SDLY:0]     r_sr;
    logic [5:0]        r_addr;
    logic [1:0]        r_rdsel;
    logic [7:0]        r_low;
    logic [31:0]       r_snap;
    logic [NCH*VW-1:0] r_vel;
    logic [13:0]       r_dout;
    logic [15:0]       r_cfg;
    logic [WDT_W-1:0]  r_cnt;
    logic              r_off;
    logic              w_edge, w_wait, w_awr, w_dacc, w_dwr, w_drd, w_kick;
    logic [15:0]       w_word;
    logic [4:0]        w_widx;
    logic [3:0]        w_grp;
    logic [31:0]       w_rd;
    logic [7:0]        w_byte;

    assign w_edge = r_sr[2:1] == 2'b01;
    assign w_wait = r_sr[SDLY];
    assign w_awr  = w_edge & ~nWrite & ~nAddrStr;
    assign w_dacc = w_edge & nAddrStr & ~nDataStr;
    assign w_dwr  = w_dacc & ~nWrite;
    assign w_drd  = w_dacc & nWrite;
    assign w_word = {pport_data, r_low};
    assign w_widx = r_addr[5:1];
    assign w_grp  = r_addr[5:2];
    assign w_kick = w_dwr & r_addr[0] & (w_widx == 5'd8) & pport_data[6];
    assign w_byte = r_snap[{r_rdsel, 3'b000} +: 8];

    assign pport_data  = (nWrite && w_wait) ? w_byte : 8'bz;
    assign nWait       = ~w_wait;
    assign vel         = r_vel;
    assign dout        = r_dout;
    assign cfg         = r_cfg;
    assign outputs_off = r_off;

    // read group mux, sampled into the snapshot on the aligned byte of a group
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NCH; i++)
            if (w_grp == 4'(i)) w_rd = pos[i*32 +: 32];
        if (w_grp == 4'd8) w_rd = {16'b0, din};
        if (w_grp == 4'd9) w_rd = {8'hA5, 5'b0, 3'(NCH - 1), 15'b0, r_off};
`ifdef PLUTO_EPP_READBACK_EN
        for (int i = 0; i < NCH; i++)
            if ({1'b0, w_grp} == 5'(10 + i)) w_rd = 32'(r_vel[i*VW +: VW]);
`endif
    end

    // strobe synchroniser; its tail is the wait handshake
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) r_sr <= '0;
        else         r_sr <= {r_sr[SDLY-1:0], ~nDataStr | ~nAddrStr};
    end

    // address pointer, write staging, register commits and read snapshot
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_addr  <= '0;
            r_rdsel <= '0;
            r_low   <= '0;
            r_snap  <= '0;
            r_vel   <= '0;
            r_dout  <= '0;
            r_cfg   <= '0;
        end else begin
            if (w_awr) r_addr <= pport_data[5:0];
            else if (w_dacc) begin
                r_addr  <= r_addr + 6'd1;
                r_rdsel <= r_addr[1:0];
            end
            if (w_dwr && !r_addr[0]) r_low <= pport_data;
            if (w_dwr && r_addr[0]) begin
                for (int i = 0; i < NCH; i++)
                    if (w_widx == 5'(i)) r_vel[i*VW +: VW] <= w_word[VW-1:0];
                if (w_widx == 5'd8) r_dout <= w_word[13:0];
                if (w_widx == 5'd9) r_cfg <= w_word;
            end
            if (w_drd && r_addr[1:0] == 2'b00) r_snap <= w_rd;
        end
    end

    // watchdog: kick reloads and enables outputs, ticks count down to shutdown
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_cnt <= '0;
            r_off <= 1'b1;
        end else if (w_kick) begin
            r_cnt <= WDT_W'(WDT_LOAD);
            r_off <= 1'b0;
        end else if (wdt_tick && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == WDT_W'(1)) r_off <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pluto_epp_regbank.sv
// tb_pluto_epp_regbank: directed self-checking bench for the EPP register bank.
module tb_pluto_epp_regbank;
    localparam int NCH = 4, VW = 12, SDLY = 4;

    logic              clk, nReset, nWrite, nDataStr, nAddrStr, wdt_tick;
    wire  [7:0]        pport_data;
    logic [7:0]        tb_data;
    logic              tb_drv;
    logic [NCH*32-1:0] pos;
    logic [15:0]       din;
    logic [NCH*VW-1:0] vel;
    logic [13:0]       dout;
    logic [15:0]       cfg;
    logic              nWait, outputs_off;
    int                n_chk = 0, n_pass = 0;
    logic [7:0]        b;
    logic [31:0]       rb;

    assign pport_data = tb_drv ? tb_data : 8'bz;

    pluto_epp_regbank #(.NCH(NCH), .VW(VW), .SDLY(SDLY)) dut (
        .clk(clk), .nReset(nReset), .pport_data(pport_data), .nWrite(nWrite),
        .nDataStr(nDataStr), .nAddrStr(nAddrStr), .nWait(nWait), .wdt_tick(wdt_tick),
        .pos(pos), .din(din), .vel(vel), .dout(dout), .cfg(cfg), .outputs_off(outputs_off)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic epp(input logic is_addr, input logic wr, input logic [7:0] d, input logic tk,
                       output logic [7:0] rd);
        nWrite = !wr;
        tb_drv = wr;
        tb_data = d;
        if (is_addr) nAddrStr = 0;
        else nDataStr = 0;
        cyc(2);
        wdt_tick = tk;
        cyc(1);
        wdt_tick = 0;
        cyc(SDLY - 3);
        check("nwait_hi", nWait, 1);
        cyc(1);
        check("nwait_lo", nWait, 0);
        rd = pport_data;
        nAddrStr = 1;
        nDataStr = 1;
        cyc(SDLY + 1);
        check("nwait_rel", nWait, 1);
        tb_drv = 0;
        nWrite = 1;
    endtask

    task automatic wa(input logic [7:0] a);
        logic [7:0] x;
        epp(1, 1, a, 0, x);
    endtask

    task automatic wd(input logic [7:0] d);
        logic [7:0] x;
        epp(0, 1, d, 0, x);
    endtask

    task automatic rd4(input string tag, input logic [31:0] exp);
        logic [7:0] x;
        for (int i = 0; i < 4; i++) begin
            epp(0, 0, 8'h00, 0, x);
            check($sformatf("%s_b%0d", tag, i), x, 64'(exp >> (8 * i)) & 64'hFF);
        end
    endtask

    task automatic pulse();
        wdt_tick = 1;
        cyc(1);
        wdt_tick = 0;
        cyc(1);
    endtask

    initial begin
        nReset = 0; nWrite = 1; nDataStr = 1; nAddrStr = 1; wdt_tick = 0;
        tb_drv = 0; tb_data = 0;
        pos = '0;
        pos[31:0] = 32'hA1B2C3D4;
        pos[63:32] = 32'h11223344;
        din = 16'hBEEF;
        cyc(2);
        check("rst_vel", vel, 0);
        check("rst_dout", dout, 0);
        check("rst_cfg", cfg, 0);
        check("rst_off", outputs_off, 1);
        check("rst_nwait", nWait, 1);
        nReset = 1;
        cyc(2);
        // word 0 write, then the pointer continues at word 1
        wa(8'h00); wd(8'h34); wd(8'h02);
        check("vel0", vel, 48'h000000000234);
        wd(8'hCD); wd(8'h0A);
        check("vel1", vel, 48'h000000ACD234);
        // little-endian group read and pointer wrap
        wa(8'h04);
        rd4("pos1", 32'h11223344);
        wa(8'h3C);
        rd4("grp15", 32'h0);
        epp(0, 0, 8'h00, 0, b);
        check("wrap_pos0", b, 8'hD4);
        // kick, partial countdown, kick coincident with tick, full countdown
        wa(8'h10); wd(8'h55); wd(8'h41);
        check("dout", dout, 14'h0155);
        check("kick_off", outputs_off, 0);
        repeat (10) pulse();
        wa(8'h10); wd(8'h55); epp(0, 1, 8'h41, 1, b);
        repeat (254) pulse();
        check("wdt_254", outputs_off, 0);
        pulse();
        check("wdt_255", outputs_off, 1);
        // unmapped word write, cfg write
        wa(8'h18); wd(8'h77); wd(8'h66);
        check("unm_vel", vel, 48'h000000ACD234);
        check("unm_dout", dout, 14'h0155);
        check("unm_cfg", cfg, 16'h0000);
        wa(8'h12); wd(8'h78); wd(8'h56);
        check("cfg", cfg, 16'h5678);
        // status and digital input groups
        wa(8'h24);
        rd4("status", 32'hA5030001);
        wa(8'h20);
        rd4("din", 32'h0000BEEF);
        // optional command word readback
        wa(8'h04); wd(8'hFF); wd(8'h07);
        check("vel2", vel, 48'h0007FFACD234);
`ifdef PLUTO_EPP_READBACK_EN
        rb = 32'h000007FF;
`else
        rb = 32'h0;
`endif
        wa(8'h30);
        rd4("rdback", rb);
        // asynchronous reset in the middle of a read access
        nWrite = 1;
        nDataStr = 0;
        cyc(SDLY + 1);
        check("mid_nwait", nWait, 0);
        #2 nReset = 0;
        #1;
        check("arst_vel", vel, 0);
        check("arst_off", outputs_off, 1);
        check("arst_nwait", nWait, 1);
        check("arst_dout", dout, 0);
        nDataStr = 1;
        cyc(2);
        nReset = 1;
        cyc(SDLY + 2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
